ahb_sram_slave: RTL
===================

# ahb_sram_slave

AHB-Lite responder that exposes a word-organised on-chip SRAM to the bus masters of the AHB system, sitting behind the interconnect decoder as a peer of the register-file, timer and APB-bridge slaves. It decodes address/control phases, performs byte-lane writes and synchronous reads with write-to-read forwarding, and signals OKAY or two-cycle ERROR responses. An optional compile-time feature inserts programmable wait states for timing-closure and latency testing.

## Interface
- DATA_WIDTH, 32, HWDATA/HRDATA width; must be 32 or 64
- ADDR_WIDTH, 32, HADDR width
- MEM_DEPTH, 64, number of DATA_WIDTH words; power of two
- WAIT_STATES, 2, extra data-phase cycles per transfer (used only with AHB_SRAM_WAIT_EN); 0..15
- HCLK  in  1  bus clock, all state on rising edge
- HRESETn  in  1  reset, asynchronous assert, active-low
- HSEL  in  1  slave select from decoder
- HADDR  in  ADDR_WIDTH  byte address
- HWRITE  in  1  1 = write, 0 = read
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type (informational only)
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HPROT  in  4  ignored
- HWDATA  in  DATA_WIDTH  write data, valid in data phase
- HREADY  in  1  bus-level ready (previous transfer complete)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  DATA_WIDTH  read data

## Operation
- Transfer accepted when HSEL & HREADY & HTRANS ∈ {NONSEQ, SEQ} at a rising edge; address, size, direction latched.
- IDLE, BUSY, or HSEL=0: no memory access; next data phase OKAY, zero wait.
- Error check at acceptance: HADDR ≥ MEM_DEPTH·DATA_WIDTH/8, HSIZE > log2(DATA_WIDTH/8), or HADDR not aligned to 2^HSIZE → ERROR response, no memory access.
- Word index = HADDR[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)]; byte lanes little-endian, enable mask derived from HSIZE and low address bits.
- Write: HWDATA sampled on the final data-phase edge (HREADYOUT=1); only enabled lanes written.
- Read: memory read issued at acceptance edge; HRDATA returns the whole word (all lanes) in the final data-phase cycle.
- Forwarding: read accepted while a write to the same word is in its final data phase returns the written lanes merged with stored lanes.
- HBURST not used for address generation; each beat's HADDR is trusted.
- State machine: IDLE → DATA on accepted OK transfer; IDLE → ERR1 on accepted bad transfer; DATA → DATA (pipelined next transfer) / IDLE when complete; ERR1 → ERR2 → IDLE/DATA/ERR1 depending on transfer presented in ERR2.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0; memory contents not reset.
- Zero-wait OK transfer: data phase one cycle, HREADYOUT=1 throughout.
- ERROR: ERR1 HREADYOUT=0 HRESP=1; ERR2 HREADYOUT=1 HRESP=1; HRESP returns 0 the following cycle unless a new error follows.
- Back-to-back NONSEQ/SEQ sustain one transfer per cycle with zero waits.
- Reset asserted mid data phase: transfer aborted, pending write not committed, outputs to reset values immediately.
- Transfer presented in ERR1 (HREADY=0) is ignored; master must re-present it.

## Configuration
- AHB_SRAM_WAIT_EN defined: every OK data phase holds HREADYOUT=0 for WAIT_STATES cycles, counter reloads per transfer, write commit and HRDATA on the last cycle; ERROR unaffected. WAIT_STATES=0 equals zero-wait.
- Undefined: counter removed, all OK transfers zero-wait; WAIT_STATES ignored.

## Structure
- Shared package ahb_pkg: htrans, hsize, hburst, hwrite, hresp enums and the slave state enum.
- Sub-module ahb_sram_mem: MEM_DEPTH×DATA_WIDTH array, synchronous read port, byte-enable write port; responder FSM, decode, error check, forwarding and wait counter stay in the top.

## Test plan
- Reset → HREADYOUT=1, HRESP=0, HRDATA=0 while HRESETn=0 and first cycle after.
- WORD write 0xA5A5_1234 @0x10, WORD read @0x10 → HRDATA=0xA5A5_1234, HRESP=0, zero wait.
- BYTE write 0x77 @0x13 over 0x0000_0000, then WORD read @0x10 back-to-back → 0x7700_0000 (forwarding).
- WORD read @0x100 (MEM_DEPTH=64) and HWORD @0x01 → ERR1 (HREADYOUT=0,HRESP=1), ERR2 (1,1), memory unchanged.
- INCR4 writes 1,2,3,4 @0x00–0x0C with one BUSY beat inserted → four OKAY beats, BUSY zero-wait OKAY, readback correct.
- With AHB_SRAM_WAIT_EN, WAIT_STATES=2: WORD read → HREADYOUT low exactly 2 cycles, data on third; reset asserted during wait on write → word unchanged.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM responder state type.
package ahb_pkg;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_DWORD,
      SIZE_4WORD, SIZE_8WORD, SIZE_16WORD, SIZE_32WORD
   } hsize_e;

   typedef enum logic [2:0] {
      BURST_SINGLE, BURST_INCR, BURST_WRAP4, BURST_INCR4,
      BURST_WRAP8, BURST_INCR8, BURST_WRAP16, BURST_INCR16
   } hburst_e;

   typedef enum logic {HWRITE_READ = 1'b0, HWRITE_WRITE = 1'b1} hwrite_e;

   typedef enum logic {RESP_OKAY = 1'b0, RESP_ERROR = 1'b1} hresp_e;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} slave_state_e;

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master/interconnect and the SRAM responder.
interface ahb_sram_slave_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) ();
   logic                   HSEL;
   logic [ADDR_WIDTH-1:0]  HADDR;
   logic                   HWRITE;
   logic [2:0]             HSIZE;
   ahb_pkg::hburst_e       HBURST;
   ahb_pkg::htrans_e       HTRANS;
   logic [3:0]             HPROT;
   logic [DATA_WIDTH-1:0]  HWDATA;
   logic                   HREADY;
   logic                   HREADYOUT;
   logic                   HRESP;
   logic [DATA_WIDTH-1:0]  HRDATA;

   modport master (
      output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HPROT, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM: registered read port, byte-enable write port, no reset.
module ahb_sram_mem #(
   parameter int  DATA_WIDTH = 32,
   parameter int  MEM_DEPTH  = 64,
   localparam int NB         = DATA_WIDTH / 8,
   localparam int IW         = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [IW-1:0]         wr_idx,
   input  logic [NB-1:0]         wr_be,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [IW-1:0]         rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data
);
   logic [DATA_WIDTH-1:0] mem_array [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_reg;

   // Read-before-write on a same-address collision; the top forwards new lanes.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) mem_array[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
      if (rd_en) rd_data_reg <= mem_array[rd_idx];
   end

   assign rd_data = rd_data_reg;
endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: decode, error check, write-to-read forwarding.
// Define AHB_SRAM_WAIT_EN to insert WAIT_STATES stall cycles per OK transfer.
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_DEPTH   = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic            HCLK,
   input  logic            HRESETn,
   ahb_sram_slave_if.slave ahb
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int BW = $clog2(NB);
   localparam int IW = $clog2(MEM_DEPTH);

   // Lanes inside the naturally aligned 2^size block that holds the low address.
   function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [BW-1:0] lo);
      logic [NB-1:0] m;
      m = '0;
      for (int b = 0; b < NB; b++) begin
         if ((b >> size) == (int'(lo) >> size)) m[b] = 1'b1;
      end
      return m;
   endfunction

   slave_state_e          state_reg;
   logic                  hreadyout_reg;
   hresp_e                hresp_reg;
   logic                  wr_reg;
   logic [IW-1:0]         idx_reg;
   logic [NB-1:0]         mask_reg;
   logic [NB-1:0]         fwd_mask_reg;
   logic [DATA_WIDTH-1:0] fwd_data_reg;

   logic                  accept, addr_oor, size_bad, misaligned, bad, commit, rd_en;
   logic [IW-1:0]         req_idx;
   logic [NB-1:0]         req_mask;
   logic [DATA_WIDTH-1:0] mem_rdata, merged;
   logic                  unused_bus;

`ifdef AHB_SRAM_WAIT_EN
   logic [3:0]            wait_cnt_reg;
`else
   logic                  unused_cfg;
   assign unused_cfg = (WAIT_STATES > 15);
`endif

   assign unused_bus = ^{ahb.HPROT, ahb.HBURST};

   // A new address phase is only taken when our own data phase is completing.
   assign accept   = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & hreadyout_reg;
   assign req_idx  = ahb.HADDR[BW +: IW];
   assign req_mask = lane_mask(ahb.HSIZE, ahb.HADDR[BW-1:0]);
   assign addr_oor = |ahb.HADDR[ADDR_WIDTH-1:BW+IW];
   assign size_bad = ahb.HSIZE > 3'(BW);

   always_comb begin
      misaligned = 1'b0;
      for (int b = 0; b < BW; b++) begin
         if (b < int'(ahb.HSIZE) && ahb.HADDR[b]) misaligned = 1'b1;
      end
   end

   assign bad    = addr_oor | size_bad | misaligned;
   assign rd_en  = accept & ~bad & ~ahb.HWRITE;
   assign commit = (state_reg == S_DATA) & wr_reg & hreadyout_reg;

   ahb_sram_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_mem (
      .clk     (HCLK),
      .wr_en   (commit),
      .wr_idx  (idx_reg),
      .wr_be   (mask_reg),
      .wr_data (ahb.HWDATA),
      .rd_en   (rd_en),
      .rd_idx  (req_idx),
      .rd_data (mem_rdata)
   );

   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign merged[gi*8 +: 8] = fwd_mask_reg[gi] ? fwd_data_reg[gi*8 +: 8] : mem_rdata[gi*8 +: 8];
   end

   assign ahb.HREADYOUT = hreadyout_reg;
   assign ahb.HRESP     = hresp_reg;
   assign ahb.HRDATA    = (state_reg == S_DATA && !wr_reg && hreadyout_reg) ? merged : '0;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_reg     <= S_IDLE;
         hreadyout_reg <= 1'b1;
         hresp_reg     <= RESP_OKAY;
         wr_reg        <= 1'b0;
         idx_reg       <= '0;
         mask_reg      <= '0;
         fwd_mask_reg  <= '0;
         fwd_data_reg  <= '0;
`ifdef AHB_SRAM_WAIT_EN
         wait_cnt_reg  <= '0;
`endif
      end else if (accept) begin
         wr_reg   <= ahb.HWRITE;
         idx_reg  <= req_idx;
         mask_reg <= req_mask;
         if (bad) begin
            state_reg     <= S_ERR1;
            hreadyout_reg <= 1'b0;
            hresp_reg     <= RESP_ERROR;
         end else begin
            state_reg <= S_DATA;
            hresp_reg <= RESP_OKAY;
`ifdef AHB_SRAM_WAIT_EN
            wait_cnt_reg  <= 4'(WAIT_STATES);
            hreadyout_reg <= (WAIT_STATES == 0);
`else
            hreadyout_reg <= 1'b1;
`endif
            if (!ahb.HWRITE) begin
               fwd_mask_reg <= (commit && idx_reg == req_idx) ? mask_reg : '0;
               fwd_data_reg <= ahb.HWDATA;
            end
         end
      end else if (state_reg == S_ERR1) begin
         state_reg     <= S_ERR2;
         hreadyout_reg <= 1'b1;
         hresp_reg     <= RESP_ERROR;
      end
`ifdef AHB_SRAM_WAIT_EN
      else if (wait_cnt_reg != 4'd0) begin
         wait_cnt_reg  <= wait_cnt_reg - 4'd1;
         hreadyout_reg <= (wait_cnt_reg == 4'd1);
      end
`endif
      else begin
         state_reg     <= S_IDLE;
         hreadyout_reg <= 1'b1;
         hresp_reg     <= RESP_OKAY;
      end
   end
endmodule
